atomic_unit: RTL and testbench
==============================

// Module: atomic_unit
// PURPOSE
// - Multi-cycle RV32A executor in the MEM stage: runs LR.W, SC.W and AMO*.W against the data-memory port.
// - Holds the LR reservation; produces atomic_unit_stall, which the hazard handler consumes to hold IF/ID/EXE.
// - While atomic_unit_stall=1 the MEM stage instruction and its operands are held stable by pipeline control.
// PARAMETERS
// - XLEN    32  data width
// - ADDR_W  32  byte address width
// PORTS
// - clk                in   1       core clock
// - rst_n              in   1       asynchronous active-low reset
// - is_atomic_mem      in   1       MEM-stage instruction is an A-extension op
// - amo_funct5_mem     in   5       funct5 of the atomic op
// - addr_mem           in   ADDR_W  effective address (rs1)
// - rs2_data_mem       in   XLEN    rs2 operand
// - store_snoop_valid  in   1       non-atomic store committing this cycle
// - store_snoop_addr   in   ADDR_W  address of that store
// - mem_req            out  1       memory request, held until mem_ack
// - mem_we             out  1       1=write, 0=read
// - mem_addr           out  ADDR_W  word-aligned request address
// - mem_wdata          out  XLEN    write data
// - mem_ack            in   1       transfer completes in cycle mem_req&mem_ack
// - mem_rdata          in   XLEN    read data, valid when mem_req&mem_ack&~mem_we
// - atomic_unit_stall  out  1       op in progress, MEM stage must hold
// - atomic_result      out  XLEN    value written to rd; valid when atomic_done
// - atomic_done        out  1       one-cycle completion pulse
// - atomic_misaligned  out  1       one-cycle pulse with atomic_done when addr_mem[1:0]!=0
// BEHAVIOUR
// - Reset (async): state=IDLE, resv_valid=0, resv_addr=0, mem_req=0, mem_we=0, atomic_result=0, atomic_done=0, atomic_misaligned=0.
// - atomic_unit_stall = is_atomic_mem & (state!=DONE) (combinational); drops exactly in the DONE cycle.
// - FSM: IDLE -> RD -> WR -> DONE -> IDLE. RD/WR hold mem_req=1 with stable addr/we/wdata until mem_ack.
// - IDLE with is_atomic_mem: misaligned -> DONE, result 0, misaligned=1, no memory access, reservation untouched.
// - LR (00010): RD; on ack result=mem_rdata, resv_valid=1, resv_addr=addr_mem[ADDR_W-1:2] -> DONE.
// - SC (00011): if resv_valid & resv_addr match in IDLE -> WR with rs2, result=0; else -> DONE, result=1, no access.
//   Any SC clears resv_valid (success or failure) when leaving IDLE.
// - AMO ops: SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
//   RD -> register old value -> WR with f(old, rs2) -> DONE; result=old value. ADD wraps mod 2^XLEN; MIN/MAX signed.
// - Unknown funct5: treated as no-op, DONE next cycle, result 0, no access.
// - Minimum latency: LR/AMO 1 cycle per transfer + DONE; failed SC/misaligned: IDLE->DONE, stall 1 cycle.
// - store_snoop_valid with word match clears resv_valid; same cycle as SC evaluation in IDLE -> snoop wins, SC fails.
// - AMO write to reservation word clears resv_valid.
// - DONE always returns to IDLE; a back-to-back atomic starts the following cycle.
// - Reset mid-transfer: mem_req drops immediately; no completion pulse; reservation lost.
// STRUCTURE
// - atomic_pkg: amo_funct5_e enum (all encodings above), atomic_state_e {IDLE,RD,WR,DONE}, XLEN default.
// - Sub-module amo_alu: combinational f(funct5, old, rs2) -> new value; instantiated once.
// - Top: FSM, old-value register, reservation register, memory interface register stage.
// TESTING
// - AMOADD.W addr 0x100, mem=0x7FFFFFFF, rs2=1, ack after 2 cycles -> write 0x80000000, result 0x7FFFFFFF, one done pulse.
// - LR.W 0x200 then SC.W 0x200 rs2=0xDEAD -> SC writes 0xDEAD, result 0; second SC.W 0x200 -> result 1, no mem_req.
// - LR.W 0x200, snoop store 0x200 same cycle SC enters IDLE -> SC result 1, no write.
// - AMOMIN.W old=0xFFFFFFFF, rs2=1 -> writes 0xFFFFFFFF; AMOMINU same values -> writes 1.
// - AMOSWAP addr 0x102 -> misaligned=1, done in 1 cycle, no mem_req; stall high exactly 1 cycle.
// - rst_n low while WR awaiting ack -> mem_req=0 immediately, state IDLE, resv_valid=0, no done pulse.

Source files
------------

// File: rtl/atomic_pkg.sv
// Shared types for the RV32A atomic executor: funct5 encodings, FSM states, width default.
package atomic_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [4:0] {
      AMO_ADD  = 5'b00000,
      AMO_SWAP = 5'b00001,
      AMO_LR   = 5'b00010,
      AMO_SC   = 5'b00011,
      AMO_XOR  = 5'b00100,
      AMO_OR   = 5'b01000,
      AMO_AND  = 5'b01100,
      AMO_MIN  = 5'b10000,
      AMO_MAX  = 5'b10100,
      AMO_MINU = 5'b11000,
      AMO_MAXU = 5'b11100
   } amo_funct5_e;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} atomic_state_e;

   // True for the read-modify-write ops (everything except LR/SC and unknown codes).
   function automatic logic is_rmw(logic [4:0] f5);
      case (f5)
         AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
         AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/atomic_unit_if.sv
// Data-memory port used by the atomic unit; master drives requests, slave answers.
interface atomic_unit_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_ack;
   logic [XLEN-1:0]   mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/atomic_unit_alu.sv
// Combinational AMO update function: new memory value from the old value and rs2.
module amo_alu
   import atomic_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [4:0]      funct5,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] rs2,
   output logic [XLEN-1:0] new_val
);

   always_comb begin
      new_val = old_val;
      case (funct5)
         AMO_ADD:  new_val = old_val + rs2;
         AMO_SWAP: new_val = rs2;
         AMO_XOR:  new_val = old_val ^ rs2;
         AMO_OR:   new_val = old_val | rs2;
         AMO_AND:  new_val = old_val & rs2;
         AMO_MIN:  new_val = ($signed(old_val) < $signed(rs2)) ? old_val : rs2;
         AMO_MAX:  new_val = ($signed(old_val) > $signed(rs2)) ? old_val : rs2;
         AMO_MINU: new_val = (old_val < rs2) ? old_val : rs2;
         AMO_MAXU: new_val = (old_val > rs2) ? old_val : rs2;
         default:  new_val = old_val;
      endcase
   end

endmodule

// File: rtl/atomic_unit.sv
// RV32A executor in the MEM stage: LR/SC reservation, AMO read-modify-write, pipeline stall.
module atomic_unit
   import atomic_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              is_atomic_mem,
   input  logic [4:0]        amo_funct5_mem,
   input  logic [ADDR_W-1:0] addr_mem,
   input  logic [XLEN-1:0]   rs2_data_mem,
   input  logic              store_snoop_valid,
   input  logic [ADDR_W-1:0] store_snoop_addr,
   atomic_unit_if.master     mem,
   output logic              atomic_unit_stall,
   output logic [XLEN-1:0]   atomic_result,
   output logic              atomic_done,
   output logic              atomic_misaligned
);

   atomic_state_e     state, state_nx;
   logic              resv_valid;
   logic [ADDR_W-3:0] resv_addr;
   logic [XLEN-1:0]   old_q;
   logic [XLEN-1:0]   alu_out;
   logic [ADDR_W-3:0] word;
   logic              misaligned, is_lr, is_sc, rmw, xfer, snoop_hit, sc_ok;

   assign word       = addr_mem[ADDR_W-1:2];
   assign misaligned = addr_mem[1:0] != 2'b00;
   assign is_lr      = amo_funct5_mem == AMO_LR;
   assign is_sc      = amo_funct5_mem == AMO_SC;
   assign rmw        = is_rmw(amo_funct5_mem);
   assign xfer       = mem.mem_req & mem.mem_ack;
   assign snoop_hit  = store_snoop_valid & resv_valid &
                       (store_snoop_addr[ADDR_W-1:2] == resv_addr);
   // A committing store to the reserved word beats an SC evaluated in the same cycle.
   assign sc_ok      = resv_valid & (resv_addr == word) & ~snoop_hit;

   assign atomic_unit_stall = is_atomic_mem & (state != DONE);

   amo_alu #(.XLEN(XLEN)) u_alu (
      .funct5  (amo_funct5_mem),
      .old_val (mem.mem_rdata),
      .rs2     (rs2_data_mem),
      .new_val (alu_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (is_atomic_mem) begin
            if (misaligned)       state_nx = DONE;
            else if (is_lr || rmw) state_nx = RD;
            else if (is_sc)       state_nx = sc_ok ? WR : DONE;
            else                  state_nx = DONE;
         end
         RD:   if (xfer) state_nx = is_lr ? DONE : WR;
         WR:   if (xfer) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resv_valid        <= 1'b0;
         resv_addr         <= '0;
         mem.mem_req       <= 1'b0;
         mem.mem_we        <= 1'b0;
         mem.mem_addr      <= '0;
         mem.mem_wdata     <= '0;
         old_q             <= '0;
         atomic_result     <= '0;
         atomic_done       <= 1'b0;
         atomic_misaligned <= 1'b0;
      end else begin
         atomic_done       <= 1'b0;
         atomic_misaligned <= 1'b0;
         if (snoop_hit) resv_valid <= 1'b0;
         case (state)
            IDLE: if (is_atomic_mem) begin
               if (misaligned) begin
                  atomic_result     <= '0;
                  atomic_misaligned <= 1'b1;
                  atomic_done       <= 1'b1;
               end else if (is_lr || rmw) begin
                  mem.mem_req  <= 1'b1;
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= {word, 2'b00};
               end else if (is_sc) begin
                  resv_valid <= 1'b0;
                  if (sc_ok) begin
                     mem.mem_req   <= 1'b1;
                     mem.mem_we    <= 1'b1;
                     mem.mem_addr  <= {word, 2'b00};
                     mem.mem_wdata <= rs2_data_mem;
                     atomic_result <= '0;
                  end else begin
                     atomic_result <= XLEN'(1);
                     atomic_done   <= 1'b1;
                  end
               end else begin
                  atomic_result <= '0;
                  atomic_done   <= 1'b1;
               end
            end
            RD: if (xfer) begin
               if (is_lr) begin
                  atomic_result <= mem.mem_rdata;
                  resv_valid    <= 1'b1;
                  resv_addr     <= word;
                  mem.mem_req   <= 1'b0;
                  atomic_done   <= 1'b1;
               end else begin
                  old_q         <= mem.mem_rdata;
                  mem.mem_we    <= 1'b1;
                  mem.mem_wdata <= alu_out;
               end
            end
            WR: if (xfer) begin
               mem.mem_req <= 1'b0;
               mem.mem_we  <= 1'b0;
               atomic_done <= 1'b1;
               if (!is_sc) begin
                  atomic_result <= old_q;
                  if (resv_valid && resv_addr == word) resv_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_atomic_unit.sv
// Directed bench for atomic_unit with a small word-addressed memory responder.
module tb_atomic_unit;
   import atomic_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        is_atomic_mem = 1'b0;
   logic [4:0]  amo_funct5_mem = '0;
   logic [31:0] addr_mem = '0;
   logic [31:0] rs2_data_mem = '0;
   logic        store_snoop_valid = 1'b0;
   logic [31:0] store_snoop_addr = '0;
   logic        atomic_unit_stall, atomic_done, atomic_misaligned;
   logic [31:0] atomic_result;

   always #5 clk = ~clk;

   atomic_unit_if mif();

   atomic_unit dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .is_atomic_mem     (is_atomic_mem),
      .amo_funct5_mem    (amo_funct5_mem),
      .addr_mem          (addr_mem),
      .rs2_data_mem      (rs2_data_mem),
      .store_snoop_valid (store_snoop_valid),
      .store_snoop_addr  (store_snoop_addr),
      .mem               (mif.master),
      .atomic_unit_stall (atomic_unit_stall),
      .atomic_result     (atomic_result),
      .atomic_done       (atomic_done),
      .atomic_misaligned (atomic_misaligned)
   );

   logic [31:0] mem [0:255];
   int  wcnt, ack_dly, req_cnt, done_cnt, total, bad;
   bit  hold_wr;

   // Responder: ack after ack_dly waiting cycles; hold_wr withholds write acks.
   always @(negedge clk) begin
      mif.mem_rdata = mem[mif.mem_addr[9:2]];
      mif.mem_ack   = mif.mem_req && (wcnt >= ack_dly) && !(hold_wr && mif.mem_we);
      if (atomic_done) done_cnt++;
   end

   always @(posedge clk) begin
      if (mif.mem_req) begin
         req_cnt++;
         if (mif.mem_ack) begin
            wcnt = 0;
            if (mif.mem_we) mem[mif.mem_addr[9:2]] = mif.mem_wdata;
         end else wcnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Drive one atomic op from a negedge until its done pulse; returns result, misaligned, stalled cycles.
   task automatic run_op(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] rs2,
                         input bit snp, output logic [31:0] res, output logic mis, output int stl);
      bit got;
      is_atomic_mem     = 1'b1;
      amo_funct5_mem    = f5;
      addr_mem          = addr;
      rs2_data_mem      = rs2;
      store_snoop_valid = snp;
      store_snoop_addr  = addr;
      stl = 0; got = 0; res = '0; mis = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         #1;
         if (atomic_done) begin
            got = 1; res = atomic_result; mis = atomic_misaligned;
         end else begin
            if (atomic_unit_stall) stl++;
            @(negedge clk);
            store_snoop_valid = 1'b0;
         end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      is_atomic_mem = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] res;
   logic        mis;
   int          stl, d0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
      chk("rst_result", atomic_result, 32'd0);
      chk("rst_done", {31'd0, atomic_done}, 32'd0);
      chk("rst_mis", {31'd0, atomic_misaligned}, 32'd0);
      chk("rst_stall", {31'd0, atomic_unit_stall}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // AMOADD wrap with slow memory: 1 idle + 3 read + 3 write stalled cycles
      mem[8'h40] = 32'h7FFF_FFFF; ack_dly = 2; req_cnt = 0; d0 = done_cnt;
      run_op(AMO_ADD, 32'h100, 32'd1, 0, res, mis, stl);
      chk("add_result", res, 32'h7FFF_FFFF);
      chk("add_mem", mem[8'h40], 32'h8000_0000);
      chk("add_pulses", done_cnt - d0, 32'd1);
      chk("add_stall", stl, 32'd7);
      chk("add_reqcyc", req_cnt, 32'd6);
      ack_dly = 0;

      // LR / SC success / SC without reservation
      mem[8'h80] = 32'h1234_5678;
      run_op(AMO_LR, 32'h200, 32'd0, 0, res, mis, stl);
      chk("lr_result", res, 32'h1234_5678);
      chk("lr_stall", stl, 32'd2);
      run_op(AMO_SC, 32'h200, 32'h0000_DEAD, 0, res, mis, stl);
      chk("sc_result", res, 32'd0);
      chk("sc_mem", mem[8'h80], 32'h0000_DEAD);
      req_cnt = 0;
      run_op(AMO_SC, 32'h200, 32'h0000_BEEF, 0, res, mis, stl);
      chk("sc2_result", res, 32'd1);
      chk("sc2_noreq", req_cnt, 32'd0);
      chk("sc2_stall", stl, 32'd1);

      // snoop store in the SC evaluation cycle kills the SC
      run_op(AMO_LR, 32'h200, 32'd0, 0, res, mis, stl);
      req_cnt = 0;
      run_op(AMO_SC, 32'h200, 32'h0000_1111, 1, res, mis, stl);
      chk("snoop_sc_result", res, 32'd1);
      chk("snoop_sc_noreq", req_cnt, 32'd0);
      chk("snoop_sc_mem", mem[8'h80], 32'h0000_DEAD);

      // signed vs unsigned min/max
      mem[8'h41] = 32'hFFFF_FFFF; mem[8'h42] = 32'hFFFF_FFFF; mem[8'h43] = 32'hFFFF_FFFF;
      run_op(AMO_MIN, 32'h104, 32'd1, 0, res, mis, stl);
      chk("min_result", res, 32'hFFFF_FFFF);
      chk("min_mem", mem[8'h41], 32'hFFFF_FFFF);
      run_op(AMO_MINU, 32'h108, 32'd1, 0, res, mis, stl);
      chk("minu_mem", mem[8'h42], 32'd1);
      run_op(AMO_MAX, 32'h10C, 32'd1, 0, res, mis, stl);
      chk("max_mem", mem[8'h43], 32'd1);
      chk("max_stall", stl, 32'd3);

      // misaligned and unknown funct5 finish without touching memory
      req_cnt = 0; d0 = done_cnt;
      run_op(AMO_SWAP, 32'h102, 32'h5555_5555, 0, res, mis, stl);
      chk("mis_flag", {31'd0, mis}, 32'd1);
      chk("mis_result", res, 32'd0);
      chk("mis_stall", stl, 32'd1);
      chk("mis_noreq", req_cnt, 32'd0);
      chk("mis_pulses", done_cnt - d0, 32'd1);
      run_op(5'b00101, 32'h110, 32'h9, 0, res, mis, stl);
      chk("unk_result", res, 32'd0);
      chk("unk_mis", {31'd0, mis}, 32'd0);
      chk("unk_noreq", req_cnt, 32'd0);

      // AMO to the reserved word drops the reservation
      mem[8'hC0] = 32'h55;
      run_op(AMO_LR, 32'h300, 32'd0, 0, res, mis, stl);
      run_op(AMO_OR, 32'h300, 32'hA0, 0, res, mis, stl);
      chk("or_result", res, 32'h55);
      chk("or_mem", mem[8'hC0], 32'hF5);
      run_op(AMO_SC, 32'h300, 32'h77, 0, res, mis, stl);
      chk("sc_after_amo", res, 32'd1);

      // reset while the write is waiting for ack
      run_op(AMO_LR, 32'h300, 32'd0, 0, res, mis, stl);
      hold_wr = 1;
      is_atomic_mem = 1'b1; amo_funct5_mem = AMO_ADD; addr_mem = 32'h300; rs2_data_mem = 32'd5;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mif.mem_req && mif.mem_we) break;
      end
      chk("rstwr_reached", {31'd0, mif.mem_req & mif.mem_we}, 32'd1);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("rstwr_req", {31'd0, mif.mem_req}, 32'd0);
      is_atomic_mem = 1'b0;
      repeat (2) @(negedge clk);
      chk("rstwr_nodone", done_cnt - d0, 32'd0);
      hold_wr = 0; wcnt = 0;
      rst_n = 1'b1;
      @(negedge clk);
      req_cnt = 0;
      run_op(AMO_SC, 32'h300, 32'h66, 0, res, mis, stl);
      chk("rstwr_sc", res, 32'd1);
      chk("rstwr_sc_noreq", req_cnt, 32'd0);
      chk("rstwr_mem", mem[8'hC0], 32'hF5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
